// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory stage that sits right after the ALU. The ALU result is used as the
//   effective address for one byte / halfword / word load or store. The access
//   goes out over a req/ack handshake to data memory. On the way out the unit
//   builds byte enables and lane-replicates store data. On the way back it
//   selects the addressed lane of the read word and sign- or zero-extends it.
//   Misaligned accesses complete at once without touching memory. Accesses
//   that get no ack within TIMEOUT request cycles end with bus_err.
//
// Handshake: mem_req rises in the cycle after an accepted start and stays high
//   with mem_we/mem_addr/mem_be/mem_wdata stable until the cycle in which
//   mem_ack=1 is sampled (zero-wait ack allowed) or the timeout fires. mem_ack
//   is only honoured while a request is outstanding.
//
// Ports
//   clk, reset   clock (rising edge), async active-high reset
//   start        one-cycle request pulse, accepted only while idle
//   mem_read     1 = load, 0 = store (sampled with start)
//   size         00 byte, 01 half, 10/11 word
//   sign_ext     loads: 1 sign-extend, 0 zero-extend
//   alu_result   effective address
//   write_data   right-justified store data
//   mem_ack      memory completion for the outstanding request
//   mem_rdata    read word, valid with mem_ack
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata   memory request, all 0 when idle
//   read_data    extended result of the last acked load
//   done         one-cycle completion pulse
//   busy         high whenever not idle
//   misalign     with done: access was misaligned
//   bus_err      with done: access timed out
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_read,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] read_data,
  output logic        done,
  output logic        busy,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // state is the FSM register; checkers can bind to it directly.
  state_t state;
  state_t next_state;

  // Access attributes captured at start, needed to decode the load result.
  logic [1:0]       addr_lo_q;
  logic [1:0]       size_q;
  logic             sext_q;
  logic             read_q;
  logic [CNT_W-1:0] cnt;

  // Request-side decode works on the live inputs: it is only loaded into the
  // output registers on the IDLE -> ACCESS transition.
  logic        mis_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  // Completion flags for the RESP cycle.
  logic set_mis;
  logic set_err;

  // Load lane selection and extension.
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  always_comb begin
    mis_in   = 1'b0;
    be_in    = 4'b1111;
    wdata_in = write_data;
    case (size)
      2'b00: begin
        be_in    = 4'b0001 << alu_result[1:0];
        wdata_in = {4{write_data[7:0]}};
      end
      2'b01: begin
        mis_in   = alu_result[0];
        be_in    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{write_data[15:0]}};
      end
      default: begin
        // 2'b11 behaves exactly like a word access.
        mis_in   = (alu_result[1:0] != 2'b00);
        be_in    = 4'b1111;
        wdata_in = write_data;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    set_mis    = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          // Misaligned accesses skip memory and report straight away.
          next_state = mis_in ? RESP : ACCESS;
          set_mis    = mis_in;
        end
      end
      ACCESS: begin
        // An ack in the last allowed cycle still wins over the timeout.
        if (mem_ack) begin
          next_state = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          next_state = RESP;
          set_err    = 1'b1;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // -------------------------------------------------------------------------
  // Load data extraction
  // -------------------------------------------------------------------------
  always_comb begin
    byte_lane = mem_rdata[7:0];
    case (addr_lo_q)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sext_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{16{sext_q & half_lane[15]}}, half_lane};
      default: load_val = mem_rdata;
    endcase
  end

  // -------------------------------------------------------------------------
  // Captured attributes, timeout counter and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_lo_q <= 2'b00;
      size_q    <= 2'b00;
      sext_q    <= 1'b0;
      read_q    <= 1'b0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      read_data <= 32'h0;
      done      <= 1'b0;
      busy      <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addr_lo_q <= alu_result[1:0];
        size_q    <= size;
        sext_q    <= sign_ext;
        read_q    <= mem_read;
      end

      // Counts request cycles that went by without an ack.
      if (state == ACCESS && next_state == ACCESS) cnt <= cnt + 1'b1;
      else                                         cnt <= '0;

      // Request bundle is loaded once on entry and held for the whole access.
      if (state == IDLE && next_state == ACCESS) begin
        mem_req   <= 1'b1;
        mem_we    <= ~mem_read;
        mem_addr  <= {alu_result[31:2], 2'b00};
        mem_be    <= be_in;
        mem_wdata <= wdata_in;
      end else if (next_state != ACCESS) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= 32'h0;
        mem_be    <= 4'h0;
        mem_wdata <= 32'h0;
      end

      if (state == ACCESS && mem_ack && read_q) read_data <= load_val;

      done     <= (next_state == RESP);
      busy     <= (next_state != IDLE);
      misalign <= set_mis;
      bus_err  <= set_err;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Drives random and directed load/store accesses into load_store_unit and
//   compares every observable output against a behavioural model written from
//   the access rules (arithmetic lane selection, replication by multiply).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mem_read;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] read_data;
  logic        done;
  logic        busy;
  logic        misalign;
  logic        bus_err;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_read   (mem_read),
    .size       (size),
    .sign_ext   (sign_ext),
    .alu_result (alu_result),
    .write_data (write_data),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .read_data  (read_data),
    .done       (done),
    .busy       (busy),
    .misalign   (misalign),
    .bus_err    (bus_err)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rd = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 4'(1 << (a % 4));
    if (sz == 2'b01) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (rd >> (8 * int'(a % 4))) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = (rd >> (16 * int'((a / 2) % 2))) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    start      = 1'b0;
    mem_read   = 1'b0;
    size       = 2'b00;
    sign_ext   = 1'b0;
    alu_result = 32'h0;
    write_data = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // One complete access. wait_cycles >= TIMEOUT means memory never acks.
  // poke_start injects an illegal start during the access, which must be ignored.
  task automatic run_access(input logic rd, input logic [1:0] sz, input logic sx,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int wait_cycles, input logic [31:0] rdata,
                            input logic poke_start);
    logic mis;
    logic acked;
    logic will_ack;
    mis      = is_misaligned(sz, a);
    will_ack = !mis && (wait_cycles < TIMEOUT);
    if (rd && will_ack) model_rd = model_load(sz, sx, a, rdata);
    exp_q.push_back(model_rd);

    @(negedge clk);
    start = 1'b1; mem_read = rd; size = sz; sign_ext = sx;
    alu_result = a; write_data = wd;
    @(negedge clk);
    start = 1'b0;
    alu_result = $urandom; write_data = $urandom; size = 2'($urandom); mem_read = 1'($urandom);
    acked = 1'b0;

    if (!mis) begin
      for (int k = 0; k < TIMEOUT; k++) begin
        check_eq("mem_req", 32'(mem_req), 32'd1);
        check_eq("mem_we", 32'(mem_we), 32'(!rd));
        check_eq("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        check_eq("mem_be", 32'(mem_be), 32'(model_be(sz, a)));
        check_eq("mem_wdata", mem_wdata, model_wdata(sz, wd));
        check_eq("busy_acc", 32'(busy), 32'd1);
        check_eq("done_acc", 32'(done), 32'd0);
        if (poke_start && k == 0) begin
          start = 1'b1; alu_result = a ^ 32'h0000_1000;
        end
        if (k == wait_cycles) begin
          mem_ack = 1'b1; mem_rdata = rdata; acked = 1'b1;
        end
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
        if (acked) break;
      end
    end

    // Completion cycle.
    check_eq("done", 32'(done), 32'd1);
    check_eq("busy_resp", 32'(busy), 32'd1);
    check_eq("misalign", 32'(misalign), 32'(mis));
    check_eq("bus_err", 32'(bus_err), 32'(!mis && !acked));
    check_eq("mem_req_resp", 32'(mem_req), 32'd0);
    check_eq("read_data", read_data, exp_q.pop_front());
    // A stray ack here must not change anything.
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("done_idle", 32'(done), 32'd0);
    check_eq("misalign_idle", 32'(misalign), 32'd0);
    check_eq("bus_err_idle", 32'(bus_err), 32'd0);
    check_eq("read_hold", read_data, model_rd);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"},  32'(mem_req), 32'd0);
    check_eq({tag, "_we"},   32'(mem_we), 32'd0);
    check_eq({tag, "_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_be"},   32'(mem_be), 32'd0);
    check_eq({tag, "_wd"},   mem_wdata, 32'd0);
    check_eq({tag, "_rd"},   read_data, 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_mis"},  32'(misalign), 32'd0);
    check_eq({tag, "_err"},  32'(bus_err), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  r_sz;
    logic [31:0] r_a;
    int          r_wait;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0);
    check_eq("word_load_lit", read_data, 32'hDEADBEEF);
    run_access(1'b1, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h80FFFFFF, 1'b0);
    check_eq("byte_sext_lit", read_data, 32'hFFFFFF80);
    run_access(1'b1, 2'b00, 1'b0, 32'h103, 32'h0, 1, 32'h80FFFFFF, 1'b0);
    check_eq("byte_zext_lit", read_data, 32'h00000080);
    run_access(1'b0, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 1, 32'h55555555, 1'b1);
    check_eq("half_store_rd", read_data, 32'h00000080);
    run_access(1'b1, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h12345678, 1'b0);
    run_access(1'b1, 2'b01, 1'b1, 32'h105, 32'h0, 0, 32'h12345678, 1'b0);
    run_access(1'b1, 2'b11, 1'b1, 32'h40, 32'h0, TIMEOUT, 32'h0, 1'b0);
    run_access(1'b1, 2'b11, 1'b0, 32'h44, 32'h0, TIMEOUT - 1, 32'hCAFEF00D, 1'b0);
    run_access(1'b1, 2'b01, 1'b1, 32'h106, 32'h0, 0, 32'h8001_7FFF, 1'b0);

    // Reset in the middle of an access, then a late ack.
    @(negedge clk);
    start = 1'b1; mem_read = 1'b1; size = 2'b10; alu_result = 32'h200;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("pre_reset_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    model_rd = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    check_all_zero("late_ack");
    run_access(1'b1, 2'b10, 1'b0, 32'h300, 32'h0, 1, 32'h0BADF00D, 1'b0);

    // Random accesses.
    for (int i = 0; i < 200; i++) begin
      r_sz = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_sz == 2'b01) r_a[0] = 1'b0;
        else if (r_sz[1]) r_a[1:0] = 2'b00;
      end
      r_wait = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 4);
      run_access(1'($urandom), r_sz, 1'($urandom), r_a, $urandom, r_wait, $urandom,
                 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
